// File: rtl/change_dispenser_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : change_dispenser_ctrl
// Purpose  : Refund controller for a coin/bill change dispenser. Pays out a
//            requested balance greedily from four stocked denominations
//            (1000/500/100/50 won), one unit at a time, handshaking with the
//            dispenser mechanism through in_disp_ready.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            in_chg_req, in_balance   - refund request and amount (won)
//            in_stock_load, in_stock_*- stock counter load (honoured in IDLE)
//            in_disp_ready            - mechanism accepts one unit this cycle
//            out_<d>won               - one-cycle dispense pulses
//            out_remain               - amount still owed
//            out_busy, out_done       - refund in progress / completion pulse
//            out_short                - last refund could not be paid exactly
//            out_state                - FSM state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_chg_req,
    input  logic [15:0] in_balance,
    input  logic        in_stock_load,
    input  logic [7:0]  in_stock_1000,
    input  logic [7:0]  in_stock_500,
    input  logic [7:0]  in_stock_100,
    input  logic [7:0]  in_stock_50,
    input  logic        in_disp_ready,
    output logic        out_1000won,
    output logic        out_500won,
    output logic        out_100won,
    output logic        out_50won,
    output logic [15:0] out_remain,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_short,
    output logic [2:0]  out_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DONE   = 3'd3
    } state_t;

    // Denomination index, ordered largest first
    localparam logic [1:0]  c_IDX_1000 = 2'd0;
    localparam logic [1:0]  c_IDX_500  = 2'd1;
    localparam logic [1:0]  c_IDX_100  = 2'd2;
    localparam logic [1:0]  c_IDX_50   = 2'd3;

    localparam logic [15:0] c_VAL_1000 = 16'd1000;
    localparam logic [15:0] c_VAL_500  = 16'd500;
    localparam logic [15:0] c_VAL_100  = 16'd100;
    localparam logic [15:0] c_VAL_50   = 16'd50;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_remain;
    logic        r_short;
    logic [1:0]  r_denom;
    logic [7:0]  r_stock [4];

    logic        w_accept;      // request taken in IDLE
    logic        w_load;        // stock load taken in IDLE
    logic        w_latch_sel;   // SELECT found a denomination
    logic        w_no_sel;      // SELECT found nothing payable
    logic        w_issue;       // unit handed to the mechanism this cycle
    logic        w_sel_found;
    logic [1:0]  w_sel_idx;
    logic [15:0] w_denom_val;

    // ------------------------------------------------------------------
    // Greedy choice: largest denomination that fits and is in stock.
    // Because d <= remain is required here, the later subtraction in
    // ISSUE can never underflow.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = c_IDX_50;
        if (r_remain >= c_VAL_1000 && r_stock[c_IDX_1000] != 8'd0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = c_IDX_1000;
        end else if (r_remain >= c_VAL_500 && r_stock[c_IDX_500] != 8'd0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = c_IDX_500;
        end else if (r_remain >= c_VAL_100 && r_stock[c_IDX_100] != 8'd0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = c_IDX_100;
        end else if (r_remain >= c_VAL_50 && r_stock[c_IDX_50] != 8'd0) begin
            w_sel_found = 1'b1;
            w_sel_idx   = c_IDX_50;
        end
    end

    always_comb begin
        w_denom_val = c_VAL_50;
        case (r_denom)
            c_IDX_1000: w_denom_val = c_VAL_1000;
            c_IDX_500:  w_denom_val = c_VAL_500;
            c_IDX_100:  w_denom_val = c_VAL_100;
            default:    w_denom_val = c_VAL_50;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_latch_sel  = 1'b0;
        w_no_sel     = 1'b0;
        w_issue      = 1'b0;
        out_busy     = 1'b1;
        out_done     = 1'b0;
        out_1000won  = 1'b0;
        out_500won   = 1'b0;
        out_100won   = 1'b0;
        out_50won    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                out_busy = 1'b0;
                w_load   = in_stock_load;
                if (in_chg_req) begin
                    w_accept     = 1'b1;
                    w_next_state = (in_balance == 16'd0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_sel_found) begin
                    w_latch_sel  = 1'b1;
                    w_next_state = ST_ISSUE;
                end else begin
                    w_no_sel     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (in_disp_ready) begin
                    w_issue      = 1'b1;
                    out_1000won  = (r_denom == c_IDX_1000);
                    out_500won   = (r_denom == c_IDX_500);
                    out_100won   = (r_denom == c_IDX_100);
                    out_50won    = (r_denom == c_IDX_50);
                    w_next_state = ST_SELECT;
                end
            end
            ST_DONE: begin
                out_done     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                // Codes 4-7 are unreachable; recover to IDLE.
                out_busy     = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: remaining amount, shortfall flag, latched denomination
    // and stock counters. Load and issue can never coincide (IDLE vs
    // ISSUE), so a counter has a single writer in any cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remain <= 16'd0;
            r_short  <= 1'b0;
            r_denom  <= c_IDX_1000;
            for (int i = 0; i < 4; i++) begin
                r_stock[i] <= 8'd0;
            end
        end else begin
            if (w_load) begin
                r_stock[c_IDX_1000] <= in_stock_1000;
                r_stock[c_IDX_500]  <= in_stock_500;
                r_stock[c_IDX_100]  <= in_stock_100;
                r_stock[c_IDX_50]   <= in_stock_50;
            end
            if (w_accept) begin
                r_remain <= in_balance;
                r_short  <= 1'b0;
            end
            if (w_latch_sel) begin
                r_denom <= w_sel_idx;
            end
            if (w_no_sel) begin
                r_short <= (r_remain != 16'd0);
            end
            if (w_issue) begin
                r_remain         <= r_remain - w_denom_val;
                r_stock[r_denom] <= r_stock[r_denom] - 8'd1;
            end
        end
    end

    assign out_remain = r_remain;
    assign out_short  = r_short;
    assign out_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser_ctrl
// Purpose  : Self-checking bench for change_dispenser_ctrl. A greedy payout
//            model (plain arithmetic over a stock array) predicts the pulse
//            sequence, final remainder and shortfall flag of every refund.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_chg_req;
    logic [15:0] in_balance;
    logic        in_stock_load;
    logic [7:0]  in_stock_1000;
    logic [7:0]  in_stock_500;
    logic [7:0]  in_stock_100;
    logic [7:0]  in_stock_50;
    logic        in_disp_ready;
    logic        out_1000won;
    logic        out_500won;
    logic        out_100won;
    logic        out_50won;
    logic [15:0] out_remain;
    logic        out_busy;
    logic        out_done;
    logic        out_short;
    logic [2:0]  out_state;

    change_dispenser_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_chg_req    (in_chg_req),
        .in_balance    (in_balance),
        .in_stock_load (in_stock_load),
        .in_stock_1000 (in_stock_1000),
        .in_stock_500  (in_stock_500),
        .in_stock_100  (in_stock_100),
        .in_stock_50   (in_stock_50),
        .in_disp_ready (in_disp_ready),
        .out_1000won   (out_1000won),
        .out_500won    (out_500won),
        .out_100won    (out_100won),
        .out_50won     (out_50won),
        .out_remain    (out_remain),
        .out_busy      (out_busy),
        .out_done      (out_done),
        .out_short     (out_short),
        .out_state     (out_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: stock per denomination, largest first
    int stock [4];
    int dval  [4] = '{1000, 500, 100, 50};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    // -1 = no pulse, 0..3 = denomination index, 9 = several at once
    function automatic int pulse_idx();
        int n;
        n = int'(out_1000won) + int'(out_500won) + int'(out_100won) + int'(out_50won);
        if (n > 1) return 9;
        if (out_1000won) return 0;
        if (out_500won)  return 1;
        if (out_100won)  return 2;
        if (out_50won)   return 3;
        return -1;
    endfunction

    task automatic load_stock(input int s0, input int s1, input int s2, input int s3);
        @(negedge clk);
        in_stock_load = 1'b1;
        in_stock_1000 = 8'(s0);
        in_stock_500  = 8'(s1);
        in_stock_100  = 8'(s2);
        in_stock_50   = 8'(s3);
        @(posedge clk);
        #1;
        in_stock_load = 1'b0;
        stock[0] = s0; stock[1] = s1; stock[2] = s2; stock[3] = s3;
    endtask

    // One complete refund; optional simultaneous stock load and random
    // ready stalls. Expected results come from the greedy model.
    task automatic run_refund(input int bal, input bit rnd, input bit do_load,
                              input int s0, input int s1, input int s2, input int s3);
        int  q[$];
        int  rem, found, cyc, last_pulse, p, np, exp_p;
        bit  done_seen, more;

        if (do_load) begin
            stock[0] = s0; stock[1] = s1; stock[2] = s2; stock[3] = s3;
        end
        rem  = bal;
        more = 1'b1;
        while (more) begin
            found = -1;
            for (int i = 0; i < 4; i++)
                if (found < 0 && dval[i] <= rem && stock[i] > 0) found = i;
            if (found < 0) begin
                more = 1'b0;
            end else begin
                q.push_back(found);
                rem -= dval[found];
                stock[found]--;
            end
        end
        np = q.size();

        @(negedge clk);
        in_chg_req    = 1'b1;
        in_balance    = 16'(bal);
        in_stock_load = do_load;
        in_stock_1000 = 8'(s0);
        in_stock_500  = 8'(s1);
        in_stock_100  = 8'(s2);
        in_stock_50   = 8'(s3);
        in_disp_ready = 1'b1;
        @(posedge clk);

        cyc        = 0;
        last_pulse = -10;
        done_seen  = 1'b0;
        while (!done_seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            in_chg_req    = 1'b0;
            in_stock_load = 1'b0;
            in_balance    = 16'($urandom);
            in_disp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (cyc == 1) begin
                chk("first_state", 32'(out_state), (bal == 0) ? 32'd3 : 32'd1);
                chk("busy_in_refund", 32'(out_busy), 32'd1);
            end
            p = pulse_idx();
            if (p != -1) begin
                exp_p = (q.size() > 0) ? q.pop_front() : -1;
                chk("pulse_denom", p, exp_p);
                chk("pulse_only_when_ready", 32'(in_disp_ready), 32'd1);
                chk("pulse_gap", (cyc - last_pulse >= 2) ? 32'd1 : 32'd0, 32'd1);
                last_pulse = cyc;
            end
            if (out_done) begin
                done_seen = 1'b1;
                chk("missing_pulses", q.size(), 0);
                chk("done_remain", 32'(out_remain), rem);
                chk("done_short", 32'(out_short), (rem != 0) ? 32'd1 : 32'd0);
                if (!rnd)
                    chk("done_cycle", cyc, (bal == 0) ? 1 : 2 * np + 2);
            end
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);

        @(negedge clk);
        #1;
        chk("idle_after_done", 32'(out_state), 32'd0);
        chk("done_one_cycle", 32'(out_done), 32'd0);
        chk("remain_held", 32'(out_remain), rem);
        chk("short_held", 32'(out_short), (rem != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int bal;
        rst           = 1'b1;
        in_chg_req    = 1'b0;
        in_balance    = 16'd0;
        in_stock_load = 1'b0;
        in_stock_1000 = 8'd0;
        in_stock_500  = 8'd0;
        in_stock_100  = 8'd0;
        in_stock_50   = 8'd0;
        in_disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) stock[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state",  32'(out_state),  32'd0);
        chk("rst_remain", 32'(out_remain), 32'd0);
        chk("rst_busy",   32'(out_busy),   32'd0);
        chk("rst_done",   32'(out_done),   32'd0);
        chk("rst_short",  32'(out_short),  32'd0);
        chk("rst_pulse",  pulse_idx(),     -1);
        rst = 1'b0;

        // Stocks are zero after reset: a 50 request cannot be paid
        run_refund(50, 1'b0, 1'b0, 0, 0, 0, 0);

        // One of each denomination
        load_stock(5, 5, 5, 5);
        run_refund(1650, 1'b0, 1'b0, 0, 0, 0, 0);

        // Exact-latency single 500 unit
        run_refund(500, 1'b0, 1'b0, 0, 0, 0, 0);

        // No 500s, only 100s
        load_stock(5, 0, 10, 0);
        run_refund(700, 1'b0, 1'b0, 0, 0, 0, 0);
        run_refund(400, 1'b0, 1'b0, 0, 0, 0, 0);

        // Non-multiple of 50
        load_stock(255, 255, 255, 255);
        run_refund(130, 1'b0, 1'b0, 0, 0, 0, 0);

        // Zero balance
        run_refund(0, 1'b0, 1'b0, 0, 0, 0, 0);

        // Load and request together: refund must use the new stock
        run_refund(1650, 1'b0, 1'b1, 0, 1, 3, 2);

        // Stall in ISSUE with ignored request / load
        load_stock(5, 5, 5, 5);
        @(negedge clk);
        in_chg_req    = 1'b1;
        in_balance    = 16'd500;
        in_disp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_chg_req = 1'b0;
        #1;
        chk("stall_select", 32'(out_state), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_chg_req    = 1'b1;
            in_balance    = 16'd50;
            in_stock_load = 1'b1;
            in_stock_1000 = 8'd0;
            in_stock_500  = 8'd0;
            in_stock_100  = 8'd0;
            in_stock_50   = 8'd0;
            in_disp_ready = 1'b0;
            #1;
            chk("stall_state",    32'(out_state),  32'd2);
            chk("stall_no_pulse", pulse_idx(),     -1);
            chk("stall_remain",   32'(out_remain), 32'd500);
        end
        @(negedge clk);
        in_chg_req    = 1'b0;
        in_stock_load = 1'b0;
        in_disp_ready = 1'b1;
        #1;
        chk("stall_release_pulse", pulse_idx(), 1);
        stock[1]--;
        @(negedge clk);
        #1;
        chk("stall_back_select", 32'(out_state),  32'd1);
        chk("stall_remain_after", 32'(out_remain), 32'd0);
        @(negedge clk);
        #1;
        chk("stall_done",  32'(out_done),  32'd1);
        chk("stall_short", 32'(out_short), 32'd0);
        // Stocks must be intact despite the ignored zero-load
        run_refund(1650, 1'b0, 1'b0, 0, 0, 0, 0);

        // Randomized refunds with random ready stalls
        for (int it = 0; it < 30; it++) begin
            bal = $urandom_range(0, 3000);
            if ($urandom_range(0, 1) == 0) bal = (bal / 50) * 50;
            if ($urandom_range(0, 2) == 0)
                run_refund(bal, 1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 4), $urandom_range(0, 4));
            else
                run_refund(bal, 1'b1, 1'b0, 0, 0, 0, 0);
        end

        // Reset one cycle after the first pulse of a 1650 refund
        load_stock(5, 5, 5, 5);
        @(negedge clk);
        in_chg_req    = 1'b1;
        in_balance    = 16'd1650;
        in_disp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_chg_req = 1'b0;
        #1;
        chk("abort_select", 32'(out_state), 32'd1);
        @(negedge clk);
        #1;
        chk("abort_first_pulse", pulse_idx(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_no_pulse_c3", pulse_idx(), -1);
        @(negedge clk);
        #1;
        chk("abort_busy",   32'(out_busy),   32'd0);
        chk("abort_remain", 32'(out_remain), 32'd0);
        chk("abort_state",  32'(out_state),  32'd0);
        chk("abort_done",   32'(out_done),   32'd0);
        chk("abort_pulse",  pulse_idx(),     -1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) stock[i] = 0;
        @(negedge clk);
        #1;
        chk("abort_no_done_after", 32'(out_done), 32'd0);
        chk("abort_no_pulse_after", pulse_idx(), -1);
        // Stocks cleared by reset: nothing payable
        run_refund(1650, 1'b0, 1'b0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser_ctrl.md
CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: CLK in 1 (all state updates on rising edge); RST in 1 (synchronous, active-high).
REQ-002 Data inputs SHALL be:
- IN_CHG_REQ in 1: start a refund of IN_BALANCE.
- IN_BALANCE in 16: amount to refund, unsigned won.
- IN_STOCK_LOAD in 1: load the four stock counters.
- IN_STOCK_1000, IN_STOCK_500, IN_STOCK_100, IN_STOCK_50 in 8 each: load values.
- IN_DISP_READY in 1: dispenser mechanism can accept one unit this cycle.
REQ-003 Outputs SHALL be:
- OUT_1000WON, OUT_500WON, OUT_100WON, OUT_50WON out 1 each: one-cycle dispense pulses.
- OUT_REMAIN out 16: amount not yet dispensed.
- OUT_BUSY out 1: a refund is in progress.
- OUT_DONE out 1: one-cycle pulse when a refund completes.
- OUT_SHORT out 1: the last refund could not be paid exactly.
- OUT_STATE out 3: FSM state code for debug.

Function
REQ-004 The FSM SHALL have states IDLE=0, SELECT=1, ISSUE=2, DONE=3; codes 4-7 SHALL be unreachable and SHALL transition to IDLE.
REQ-005 IDLE behaviour:
- OUT_BUSY=0.
- When IN_CHG_REQ=1: REMAIN<=IN_BALANCE, OUT_SHORT<=0, next state SELECT; if IN_BALANCE=0, next state DONE instead.
REQ-006 IN_CHG_REQ SHALL be ignored in every state other than IDLE; OUT_BUSY=1 in SELECT, ISSUE and DONE.
REQ-007 SELECT SHALL choose the largest denomination d in {1000,500,100,50} with d<=REMAIN and stock_d>0, then go to ISSUE with d latched.
REQ-008 If SELECT finds no such d, it SHALL go to DONE, setting OUT_SHORT<=1 if REMAIN!=0, else OUT_SHORT<=0.
REQ-009 ISSUE behaviour:
- While IN_DISP_READY=0: hold state and assert no pulse.
- In the cycle IN_DISP_READY=1: assert OUT_<d>WON combinationally for that cycle only; at the edge REMAIN<=REMAIN-d, stock_d<=stock_d-1, next state SELECT.
REQ-010 At most one dispense pulse SHALL be high in any cycle; pulses SHALL be at least 2 cycles apart (ISSUE->SELECT->ISSUE).
REQ-011 DONE SHALL assert OUT_DONE=1 for exactly one cycle, then return to IDLE.
REQ-012 OUT_REMAIN and OUT_SHORT SHALL hold their final values until the next accepted request or RST.
REQ-013 Arithmetic SHALL be 16-bit unsigned; REMAIN never underflows because d<=REMAIN is checked in SELECT. Stock counters are 8-bit, never decrement below 0, and do not wrap.
REQ-014 IN_STOCK_LOAD SHALL take effect only in IDLE and be ignored otherwise. If IN_STOCK_LOAD and IN_CHG_REQ are both high in IDLE, both are performed, and the refund SHALL use the newly loaded stock.
REQ-015 Latency with IN_DISP_READY=1, ample stock and IN_BALANCE=500 (request sampled at edge 0):
- SELECT in cycle 1.
- OUT_500WON in cycle 2.
- SELECT in cycle 3.
- OUT_DONE in cycle 4.
- IDLE in cycle 5.
REQ-016 A balance that is not a multiple of 50 SHALL be paid down to the residue below 50, then finish with OUT_SHORT=1.

Reset
REQ-017 In the cycle after RST=1 is sampled, the block SHALL be in the following state:
- state=IDLE.
- REMAIN=0 and all stock counters=0.
- OUT_BUSY=OUT_DONE=OUT_SHORT=0 and all dispense pulses=0.
REQ-018 RST SHALL take priority over all other inputs. RST asserted mid-refund SHALL abort it with no further pulses and no OUT_DONE.

Verification
REQ-019 Load all stocks=5, then IN_BALANCE=1650 with READY=1 -> pulses 1000, 500, 100, 50 in order, 2 cycles apart; OUT_DONE then fires with OUT_REMAIN=0 and OUT_SHORT=0.
REQ-020 Stock 500=0, stock 100=10, IN_BALANCE=700 -> exactly seven OUT_100WON pulses, OUT_REMAIN=0, OUT_SHORT=0, stock_100 left at 3 (a second 400 request gives three 100 pulses and OUT_SHORT=1 with OUT_REMAIN=100).
REQ-021 Full stock, IN_BALANCE=130 -> one OUT_100WON pulse, OUT_DONE, OUT_SHORT=1, OUT_REMAIN=30.
REQ-022 Hold READY=0 for 5 cycles in ISSUE and pulse IN_CHG_REQ and IN_STOCK_LOAD meanwhile -> no dispense pulse, state stays 2, stocks and REMAIN unchanged; the pulse appears in the first READY=1 cycle.
REQ-023 IN_BALANCE=0 -> OUT_DONE one cycle after the request, with no pulses and OUT_SHORT=0.
REQ-024 Assert RST one cycle after the first pulse of a 1650 refund -> no further pulses, no OUT_DONE, and OUT_BUSY=0, OUT_REMAIN=0, stocks=0 in the next cycle.
